epc_master_arb: RTL and testbench
=================================

Name: epc_master_arb

Overview:
- Round-robin arbiter and bus sequencer for the EPC external-peripheral interface. It shares one EPC master port between NREQ internal requesters.
- It turns each granted single-word request into one non-burst EPC cycle: chip select, address strobe, read/write strobe, ready wait and data capture.
- It sits between the on-chip register masters (bring-up sequencer, status poller) and the EPC_INTF_* pins of the cpu block.
- A ready timeout keeps a stuck peripheral from blocking the bus.

Parameters:
- NREQ, 2, number of requesters (1..8).
- TIMEOUT, 64, max cycles spent in STROBE+WAIT without rdy before the transaction is aborted (4..1023).

Ports:
- EPC_INTF_clk  in  1  bus clock; all logic on rising edge.
- EPC_INTF_rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester request; held with its fields until its ack.
- req_rnw  in  NREQ  1=read, 0=write.
- req_addr  in  NREQ*32  requester i occupies bits [32i+31:32i].
- req_wdata  in  NREQ*32  write data, same packing.
- req_be  in  NREQ*4  byte enables, same packing; bit 3 = MSB byte.
- req_ack  out  NREQ  one-cycle completion pulse to the granted requester.
- rsp_err  out  1  valid with ack; 1 = timeout.
- rsp_rdata  out  32  read data, valid with ack.
- busy  out  1  high from ADDR through DONE.
- EPC_INTF_cs_n  out  [0:0]  chip select, active-low.
- EPC_INTF_ads  out  1  address strobe.
- EPC_INTF_addr  out  [0:31]  address.
- EPC_INTF_be  out  [0:3]  byte enables.
- EPC_INTF_rnw  out  1  read/not-write.
- EPC_INTF_rd_n  out  1  read strobe.
- EPC_INTF_wr_n  out  1  write strobe.
- EPC_INTF_burst  out  1  burst; constant 0.
- EPC_INTF_data_o  out  [0:31]  write data.
- EPC_INTF_data_t  out  [0:31]  tristate control; 1 = input.
- EPC_INTF_data_i  in  [0:31]  read data.
- EPC_INTF_rdy  in  [0:0]  peripheral ready.

Behaviour:
- Clocking and reset: single clock EPC_INTF_clk. Reset EPC_INTF_rst is synchronous and active-high. All outputs are registered.
- Bit order: EPC vectors are big-endian. Internal bit k maps to EPC bit 31-k (addr and data) or EPC bit 3-k (be).
- Reset values:
  - cs_n=1, ads=0, rd_n=1, wr_n=1, rnw=1, burst=0.
  - addr=0, be=0, data_o=0, data_t=all 1s.
  - req_ack=0, rsp_err=0, rsp_rdata=0, busy=0.
  - state=IDLE, round-robin pointer=NREQ-1, so requester 0 wins the first arbitration.
- FSM states: IDLE, ADDR, STROBE, WAIT, DONE.
- IDLE:
  - If any req_valid is sampled at edge n, the winner is the first valid index scanning upward (mod NREQ) from pointer+1.
  - On the winner: latch its rnw/addr/be/wdata, set pointer=winner, go to ADDR.
- ADDR (cycle n+1):
  - cs_n=0, ads=1, addr/be/rnw driven.
  - For a write, data_o=wdata and data_t=all 0s.
- STROBE (n+2):
  - ads=0; rd_n=0 (read) or wr_n=0 (write).
  - Clear the timeout counter, then count each cycle spent in STROBE and WAIT.
  - rdy is sampled at every edge in STROBE and WAIT.
- Ready handling:
  - If rdy=1 is sampled: capture data_i as rsp_rdata (read only; write leaves rsp_rdata unchanged), set err=0, go to DONE.
  - Otherwise stay in WAIT.
- Timeout: when the counter reaches TIMEOUT, go to DONE with err=1 and rsp_rdata=0 for a read.
- DONE (one cycle):
  - cs_n=1, rd_n=wr_n=1, data_t=all 1s.
  - req_ack[grant]=1 and rsp_err valid.
  - Next state is IDLE.
- Minimum latency: req_valid at n with rdy already high gives ack at n+3. The earliest next ADDR is n+5, since IDLE always lasts at least one cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NREQ-1,0.
- Requester behaviour during a transaction:
  - A requester dropping valid mid-transaction does not abort it; the transaction completes and ack is still issued.
  - A new request on a non-granted port waits.
  - Changing fields after grant has no effect; fields are latched in IDLE.
- rdy=1 already high in STROBE's first cycle is legal and completes immediately.
- rdy outside STROBE/WAIT is ignored.
- Reset mid-transaction: outputs return to reset values at the next edge, no ack is generated, and pointer is reset.
- busy=1 in ADDR, STROBE, WAIT and DONE.

Test Plan:
1. Reset with rdy=0: all outputs at the reset values listed above; hold 10 cycles with no request → no change.
2. Write: req0 write, addr 0x0000_0010, wdata 0x1234_5678, be 0xF, rdy tied 1.
   - Next cycle: ads=1 and EPC_INTF_addr[27]=1.
   - Write strobe: wr_n=0 for 1 cycle and data_t=0.
   - Completion: req_ack=01 at n+3 with err=0.
3. Read: req1 read, addr 0x40, rdy asserted 3 cycles after STROBE, data_i=0xCAFE_F00D.
   - rd_n low 4 cycles.
   - ack=10, rsp_rdata=0xCAFE_F00D, err=0.
4. Arbitration: req0 and req1 both valid continuously for 4 transactions → grant order 0,1,0,1 with no overlapping cs_n.
5. Timeout: TIMEOUT=8, rdy never asserted → ack after exactly 8 cycles in STROBE+WAIT, rsp_err=1, rsp_rdata=0, and the bus returns to idle.
6. Reset pulse in WAIT:
   - Next cycle: cs_n=1, rd_n=1, no ack.
   - Following request from req1 alongside req0 → req0 granted first (pointer reset).

Source files
------------

// File: rtl/epc_master_arb.sv
// epc_master_arb
// Round-robin arbiter and single-word EPC bus sequencer. Up to NREQ internal
// requesters share one EPC master port. Each granted request becomes one
// non-burst EPC cycle: IDLE -> ADDR -> STROBE -> WAIT* -> DONE -> IDLE.
//
// Ports
//   EPC_INTF_clk, EPC_INTF_rst : clock, synchronous active-high reset
//   req_valid/rnw/addr/wdata/be : per-requester request, packed 32/4 bits per index
//   req_ack, rsp_err, rsp_rdata : one-cycle completion to the granted requester
//   busy                        : high from ADDR through DONE
//   EPC_INTF_*                  : big-endian EPC master pins (addr/data [0:31], be [0:3])
//
// The EPC vectors are declared [0:N] so plain assignment from an internal
// [N:0] vector maps internal bit k onto EPC bit N-k.
module epc_master_arb #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic               EPC_INTF_clk,
    input  logic               EPC_INTF_rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_rnw,
    input  logic [NREQ*32-1:0] req_addr,
    input  logic [NREQ*32-1:0] req_wdata,
    input  logic [NREQ*4-1:0]  req_be,
    output logic [NREQ-1:0]    req_ack,
    output logic               rsp_err,
    output logic [31:0]        rsp_rdata,
    output logic               busy,
    output logic [0:0]         EPC_INTF_cs_n,
    output logic               EPC_INTF_ads,
    output logic [0:31]        EPC_INTF_addr,
    output logic [0:3]         EPC_INTF_be,
    output logic               EPC_INTF_rnw,
    output logic               EPC_INTF_rd_n,
    output logic               EPC_INTF_wr_n,
    output logic               EPC_INTF_burst,
    output logic [0:31]        EPC_INTF_data_o,
    output logic [0:31]        EPC_INTF_data_t,
    input  logic [0:31]        EPC_INTF_data_i,
    input  logic [0:0]         EPC_INTF_rdy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = 10;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        STROBE,
        WAIT,
        DONE
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   grant_q;
    logic [CW-1:0]   cnt_q;

    logic            found_d;
    logic [PW-1:0]   win_d;

    assign EPC_INTF_burst = 1'b0;

    // First valid requester scanning upward from ptr_q+1, wrapping at NREQ.
    always_comb begin
        found_d = 1'b0;
        win_d   = ptr_q;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            int unsigned idx;
            idx = (32'(ptr_q) + k) % NREQ;
            if (!found_d && req_valid[PW'(idx)]) begin
                found_d = 1'b1;
                win_d   = PW'(idx);
            end
        end
    end

    always_ff @(posedge EPC_INTF_clk) begin
        if (EPC_INTF_rst) begin
            state_q         <= IDLE;
            ptr_q           <= PW'(NREQ - 1);
            grant_q         <= '0;
            cnt_q           <= '0;
            req_ack         <= '0;
            rsp_err         <= 1'b0;
            rsp_rdata       <= '0;
            busy            <= 1'b0;
            EPC_INTF_cs_n   <= 1'b1;
            EPC_INTF_ads    <= 1'b0;
            EPC_INTF_addr   <= '0;
            EPC_INTF_be     <= '0;
            EPC_INTF_rnw    <= 1'b1;
            EPC_INTF_rd_n   <= 1'b1;
            EPC_INTF_wr_n   <= 1'b1;
            EPC_INTF_data_o <= '0;
            EPC_INTF_data_t <= '1;
        end else begin
            req_ack <= '0;
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        // Request fields are captured here; later changes are ignored.
                        ptr_q         <= win_d;
                        grant_q       <= win_d;
                        EPC_INTF_addr <= req_addr[32*win_d +: 32];
                        EPC_INTF_be   <= req_be[4*win_d +: 4];
                        EPC_INTF_rnw  <= req_rnw[win_d];
                        if (!req_rnw[win_d]) begin
                            EPC_INTF_data_o <= req_wdata[32*win_d +: 32];
                            EPC_INTF_data_t <= '0;
                        end
                        EPC_INTF_cs_n <= 1'b0;
                        EPC_INTF_ads  <= 1'b1;
                        busy          <= 1'b1;
                        state_q       <= ADDR;
                    end
                end

                ADDR: begin
                    EPC_INTF_ads <= 1'b0;
                    if (EPC_INTF_rnw) begin
                        EPC_INTF_rd_n <= 1'b0;
                    end else begin
                        EPC_INTF_wr_n <= 1'b0;
                    end
                    cnt_q   <= '0;
                    state_q <= STROBE;
                end

                STROBE, WAIT: begin
                    // cnt_q holds the number of strobe cycles already completed,
                    // so reaching TIMEOUT-1 here means this is cycle TIMEOUT.
                    if (EPC_INTF_rdy[0] || (cnt_q == CW'(TIMEOUT - 1))) begin
                        if (EPC_INTF_rdy[0]) begin
                            rsp_err <= 1'b0;
                            if (EPC_INTF_rnw) begin
                                rsp_rdata <= EPC_INTF_data_i;
                            end
                        end else begin
                            rsp_err <= 1'b1;
                            if (EPC_INTF_rnw) begin
                                rsp_rdata <= '0;
                            end
                        end
                        EPC_INTF_cs_n    <= 1'b1;
                        EPC_INTF_rd_n    <= 1'b1;
                        EPC_INTF_wr_n    <= 1'b1;
                        EPC_INTF_data_t  <= '1;
                        req_ack[grant_q] <= 1'b1;
                        state_q          <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                        state_q <= WAIT;
                    end
                end

                DONE: begin
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epc_master_arb.sv
// Directed testbench for epc_master_arb (NREQ=2, TIMEOUT=8). Stimulus pushes
// the expected completion into a queue; a monitor pops and compares on ack.
module tb_epc_master_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_rnw, req_ack;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_be;
    logic        rsp_err, busy;
    logic [31:0] rsp_rdata;
    logic [0:0]  cs_n, rdy;
    logic        ads, rnw, rd_n, wr_n, burst;
    logic [0:31] e_addr, data_o, data_t, data_i;
    logic [0:3]  e_be;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [1:0]  ack;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    epc_master_arb #(.NREQ(2), .TIMEOUT(8)) dut (
        .EPC_INTF_clk    (clk),
        .EPC_INTF_rst    (rst),
        .req_valid       (req_valid),
        .req_rnw         (req_rnw),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_be          (req_be),
        .req_ack         (req_ack),
        .rsp_err         (rsp_err),
        .rsp_rdata       (rsp_rdata),
        .busy            (busy),
        .EPC_INTF_cs_n   (cs_n),
        .EPC_INTF_ads    (ads),
        .EPC_INTF_addr   (e_addr),
        .EPC_INTF_be     (e_be),
        .EPC_INTF_rnw    (rnw),
        .EPC_INTF_rd_n   (rd_n),
        .EPC_INTF_wr_n   (wr_n),
        .EPC_INTF_burst  (burst),
        .EPC_INTF_data_o (data_o),
        .EPC_INTF_data_t (data_t),
        .EPC_INTF_data_i (data_i),
        .EPC_INTF_rdy    (rdy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] b);
        req_rnw[i]          = r;
        req_addr[32*i +: 32]  = a;
        req_wdata[32*i +: 32] = wd;
        req_be[4*i +: 4]      = b;
    endtask

    // Steps negedges until an ack appears; counts strobe-low cycles and raises
    // rdy once the strobe has been low for rdy_at cycles (0 = leave rdy alone).
    task automatic run_until_ack(input int rdy_at, output int low, output bit got);
        low = 0;
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (!rd_n || !wr_n) low++;
            if (rdy_at > 0 && low == rdy_at) rdy = 1'b1;
            if (req_ack != 2'b00) got = 1'b1;
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst === 1'b0 && req_ack != 2'b00) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {62'b0, req_ack}, 64'h0);
            end else begin
                e = sb.pop_front();
                chk("ack_vec", {62'b0, req_ack}, {62'b0, e.ack});
                chk("rsp_err", {63'b0, rsp_err}, {63'b0, e.err});
                chk("rsp_rdata", {32'b0, rsp_rdata}, {32'b0, e.rdata});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int  low;
        bit  got;
        int  acks;
        int  t[5];

        rst = 1'b1; req_valid = '0; req_rnw = '0; req_addr = '0;
        req_wdata = '0; req_be = '0; rdy = 1'b0; data_i = '0;

        // 1. Reset values
        repeat (3) @(negedge clk);
        chk("rst_cs_n", {63'b0, cs_n}, 64'h1);
        chk("rst_ads", {63'b0, ads}, 64'h0);
        chk("rst_rd_wr", {62'b0, rd_n, wr_n}, 64'h3);
        chk("rst_rnw_burst", {62'b0, rnw, burst}, 64'h2);
        chk("rst_addr", {32'b0, e_addr}, 64'h0);
        chk("rst_be", {60'b0, e_be}, 64'h0);
        chk("rst_data_o", {32'b0, data_o}, 64'h0);
        chk("rst_data_t", {32'b0, data_t}, 64'hFFFF_FFFF);
        chk("rst_ack_err_busy", {60'b0, req_ack, rsp_err, busy}, 64'h0);
        chk("rst_rdata", {32'b0, rsp_rdata}, 64'h0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_hold", {61'b0, cs_n, ads, busy}, 64'h4);
        end

        // 2. Write from req0, rdy already high
        set_req(0, 1'b0, 32'h0000_0010, 32'h1234_5678, 4'hF);
        rdy = 1'b1;
        req_valid = 2'b01;
        sb.push_back({2'b01, 1'b0, 32'h0});
        @(negedge clk);
        chk("wr_addr_phase", {61'b0, ads, cs_n, busy}, 64'h5);
        chk("wr_addr_bit27", {63'b0, e_addr[27]}, 64'h1);
        chk("wr_addr", {32'b0, e_addr}, 64'h10);
        chk("wr_be", {60'b0, e_be}, 64'hF);
        chk("wr_data_o", {32'b0, data_o}, 64'h1234_5678);
        chk("wr_data_t", {32'b0, data_t}, 64'h0);
        @(negedge clk);
        chk("wr_strobe", {61'b0, ads, rd_n, wr_n}, 64'h2);
        chk("wr_strobe_data_t", {32'b0, data_t}, 64'h0);
        @(negedge clk);
        chk("wr_ack_n3", {62'b0, req_ack}, 64'h1);
        chk("wr_done_pins", {61'b0, cs_n, wr_n, busy}, 64'h7);
        chk("wr_done_data_t", {32'b0, data_t}, 64'hFFFF_FFFF);
        req_valid = 2'b00;
        @(negedge clk);
        chk("wr_idle", {61'b0, busy, req_ack}, 64'h0);

        // 3. Read from req1, rdy raised in the 4th strobe cycle
        rdy = 1'b0;
        set_req(1, 1'b1, 32'h0000_0040, 32'h0, 4'hF);
        data_i = 32'hCAFE_F00D;
        req_valid = 2'b10;
        sb.push_back({2'b10, 1'b0, 32'hCAFE_F00D});
        run_until_ack(4, low, got);
        req_valid = 2'b00;
        rdy = 1'b0;
        chk("rd_got_ack", {63'b0, got}, 64'h1);
        chk("rd_rd_n_low", 64'(low), 64'd4);

        // 4. Both requesters valid: 0,1,0,1 with 4-cycle ack spacing
        @(negedge clk);
        rdy = 1'b1;
        set_req(0, 1'b0, 32'h0000_0100, 32'hA5A5_A5A5, 4'h3);
        set_req(1, 1'b1, 32'h0000_0104, 32'h0, 4'hC);
        data_i = 32'h1111_2222;
        sb.push_back({2'b01, 1'b0, 32'hCAFE_F00D});
        sb.push_back({2'b10, 1'b0, 32'h1111_2222});
        sb.push_back({2'b01, 1'b0, 32'h1111_2222});
        sb.push_back({2'b10, 1'b0, 32'h1111_2222});
        req_valid = 2'b11;
        acks = 0;
        for (int c = 0; c < 60 && acks < 4; c++) begin
            @(negedge clk);
            if (req_ack != 2'b00) begin
                acks++;
                t[acks] = c;
            end
        end
        req_valid = 2'b00;
        chk("arb_ack_count", 64'(acks), 64'd4);
        chk("arb_spacing_12", 64'(t[2] - t[1]), 64'd4);
        chk("arb_spacing_34", 64'(t[4] - t[3]), 64'd4);

        // 5. Timeout on a read from req0
        @(negedge clk);
        rdy = 1'b0;
        set_req(0, 1'b1, 32'h0000_0200, 32'h0, 4'hF);
        req_valid = 2'b01;
        sb.push_back({2'b01, 1'b1, 32'h0});
        run_until_ack(0, low, got);
        req_valid = 2'b00;
        chk("to_got_ack", {63'b0, got}, 64'h1);
        chk("to_strobe_cycles", 64'(low), 64'd8);
        @(negedge clk);
        chk("to_bus_idle", {61'b0, cs_n, rd_n, busy}, 64'h6);

        // 6. Reset while in WAIT, then pointer restarts at requester 0
        set_req(0, 1'b1, 32'h0000_0300, 32'h0, 4'hF);
        req_valid = 2'b01;
        low = 0;
        for (int c = 0; c < 10 && low < 2; c++) begin
            @(negedge clk);
            if (!rd_n) low++;
        end
        chk("rstw_reached_wait", 64'(low), 64'd2);
        rst = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rstw_pins", {61'b0, cs_n, rd_n, busy}, 64'h6);
        chk("rstw_no_ack", {62'b0, req_ack}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        rdy = 1'b1;
        set_req(0, 1'b0, 32'h0000_0304, 32'h0000_DEAD, 4'h1);
        set_req(1, 1'b1, 32'h0000_0308, 32'h0, 4'hF);
        sb.push_back({2'b01, 1'b0, 32'h0});
        req_valid = 2'b11;
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (req_ack != 2'b00) got = 1'b1;
        end
        req_valid = 2'b00;
        chk("rstw_got_ack", {63'b0, got}, 64'h1);

        repeat (4) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
